nf_ahb_mem_bridge: RTL and testbench

AHB-Lite slave (responder) that sits on one slave port of the AHB router and converts pipelined AHB address/data phases into a simple single-port word memory/register interface. It registers the address phase and inserts a programmable number of wait states. It issues one write or read strobe per transfer and returns read data with hreadyout/hresp. Misaligned accesses get a two-cycle ERROR response and never reach the memory side.

---
 rtl/nf_ahb_mem_bridge_if.sv | 22 ++
 rtl/nf_ahb_mem_bridge.sv | 113 +++++++++++
 tb/tb_nf_ahb_mem_bridge.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/nf_ahb_mem_bridge_if.sv
// rtl/nf_ahb_mem_bridge_if.sv - AHB-Lite slave-port signal bundle for the memory bridge
interface nf_ahb_mem_bridge_if;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [31:0] hwdata;
    logic        hready;
    logic [31:0] hrdata;
    logic        hreadyout;
    logic        hresp;

    modport master (
        output hsel, haddr, htrans, hwrite, hwdata, hready,
        input  hrdata, hreadyout, hresp
    );

    modport slave (
        input  hsel, haddr, htrans, hwrite, hwdata, hready,
        output hrdata, hreadyout, hresp
    );
endinterface

// File: rtl/nf_ahb_mem_bridge.sv
// rtl/nf_ahb_mem_bridge.sv - AHB-Lite slave to single-port word memory bridge with wait states
module nf_ahb_mem_bridge #(
    parameter int unsigned WAIT_C = 0,
    parameter int unsigned MEM_AW = 10
) (
    input  logic              hclk,
    input  logic              hresetn,
    nf_ahb_mem_bridge_if.slave ahb,
    output logic [MEM_AW-1:0] mem_addr,
    output logic              mem_we,
    output logic [31:0]       mem_wd,
    output logic              mem_re,
    input  logic [31:0]       mem_rd
);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT, S_ACCESS, S_RDATA, S_ERR1, S_ERR2
    } state_t;

    localparam bit         HAS_WAIT  = (WAIT_C != 0);
    localparam logic [3:0] WAIT_INIT = (WAIT_C == 0) ? 4'd0 : 4'(WAIT_C - 1);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [MEM_AW-1:0] addr_q, addr_d;
    logic              write_q, write_d;
    logic              ready;
    logic              resp;
    logic [31:0]       rdata;
    logic              accept;

    assign accept = ahb.hsel & ahb.htrans[1] & ahb.hready & ready;

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            write_q <= write_d;
        end
    end

    // Acceptance only happens in ready states, so it takes priority and gives
    // back-to-back transfers with no idle bubble.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        write_d = write_q;
        if (accept) begin
            addr_d  = ahb.haddr[MEM_AW+1:2];
            write_d = ahb.hwrite;
            if (ahb.haddr[1:0] != 2'b00) begin
                state_d = S_ERR1;
            end else if (HAS_WAIT) begin
                state_d = S_WAIT;
                cnt_d   = WAIT_INIT;
            end else begin
                state_d = S_ACCESS;
            end
        end else begin
            case (state_q)
                S_WAIT: begin
                    if (cnt_q == 4'd0) state_d = S_ACCESS;
                    else               cnt_d   = cnt_q - 4'd1;
                end
                S_ACCESS: state_d = write_q ? S_IDLE : S_RDATA;
                S_ERR1:   state_d = S_ERR2;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        ready    = 1'b1;
        resp     = 1'b0;
        rdata    = 32'd0;
        mem_we   = 1'b0;
        mem_re   = 1'b0;
        mem_addr = '0;
        mem_wd   = 32'd0;
        case (state_q)
            S_WAIT: ready = 1'b0;
            S_ACCESS: begin
                mem_addr = addr_q;
                if (write_q) begin
                    mem_we = 1'b1;
                    mem_wd = ahb.hwdata;
                end else begin
                    mem_re = 1'b1;
                    ready  = 1'b0;
                end
            end
            S_RDATA: rdata = mem_rd;
            S_ERR1: begin
                resp  = 1'b1;
                ready = 1'b0;
            end
            S_ERR2: resp = 1'b1;
            default: ;
        endcase
    end

    assign ahb.hreadyout = ready;
    assign ahb.hresp     = resp;
    assign ahb.hrdata    = rdata;

endmodule

// File: tb/tb_nf_ahb_mem_bridge.sv
// tb/tb_nf_ahb_mem_bridge.sv - directed scoreboard bench for nf_ahb_mem_bridge
module tb_nf_ahb_mem_bridge;

    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_BUSY   = 2'b01;
    localparam logic [1:0] T_NONSEQ = 2'b10;

    logic hclk = 1'b0;
    always #5 hclk = ~hclk;

    logic        hresetn;
    logic        t_hsel;
    logic [31:0] t_haddr;
    logic [1:0]  t_htrans;
    logic        t_hwrite;
    logic [31:0] t_hwdata;
    logic        t_hready;
    int          sel;

    nf_ahb_mem_bridge_if if0();
    nf_ahb_mem_bridge_if if2();
    nf_ahb_mem_bridge_if if3();

    assign if0.hsel = t_hsel && (sel == 0);
    assign if2.hsel = t_hsel && (sel == 2);
    assign if3.hsel = t_hsel && (sel == 3);
    assign if0.haddr = t_haddr;   assign if2.haddr = t_haddr;   assign if3.haddr = t_haddr;
    assign if0.htrans = t_htrans; assign if2.htrans = t_htrans; assign if3.htrans = t_htrans;
    assign if0.hwrite = t_hwrite; assign if2.hwrite = t_hwrite; assign if3.hwrite = t_hwrite;
    assign if0.hwdata = t_hwdata; assign if2.hwdata = t_hwdata; assign if3.hwdata = t_hwdata;
    assign if0.hready = t_hready; assign if2.hready = t_hready; assign if3.hready = t_hready;

    logic [9:0]  ma0, ma2, ma3;
    logic        we0, we2, we3, re0, re2, re3;
    logic [31:0] wd0, wd2, wd3;
    logic [31:0] mem_rd;

    nf_ahb_mem_bridge #(.WAIT_C(0), .MEM_AW(10)) u_w0 (
        .hclk(hclk), .hresetn(hresetn), .ahb(if0),
        .mem_addr(ma0), .mem_we(we0), .mem_wd(wd0), .mem_re(re0), .mem_rd(mem_rd));
    nf_ahb_mem_bridge #(.WAIT_C(2), .MEM_AW(10)) u_w2 (
        .hclk(hclk), .hresetn(hresetn), .ahb(if2),
        .mem_addr(ma2), .mem_we(we2), .mem_wd(wd2), .mem_re(re2), .mem_rd(mem_rd));
    nf_ahb_mem_bridge #(.WAIT_C(3), .MEM_AW(10)) u_w3 (
        .hclk(hclk), .hresetn(hresetn), .ahb(if3),
        .mem_addr(ma3), .mem_we(we3), .mem_wd(wd3), .mem_re(re3), .mem_rd(mem_rd));

    logic [31:0] o_hrdata, o_wd;
    logic        o_rdy, o_resp, o_we, o_re;
    logic [9:0]  o_ma;

    always_comb begin
        o_hrdata = if0.hrdata; o_rdy = if0.hreadyout; o_resp = if0.hresp;
        o_we = we0; o_re = re0; o_ma = ma0; o_wd = wd0;
        if (sel == 2) begin
            o_hrdata = if2.hrdata; o_rdy = if2.hreadyout; o_resp = if2.hresp;
            o_we = we2; o_re = re2; o_ma = ma2; o_wd = wd2;
        end else if (sel == 3) begin
            o_hrdata = if3.hrdata; o_rdy = if3.hreadyout; o_resp = if3.hresp;
            o_we = we3; o_re = re3; o_ma = ma3; o_wd = wd3;
        end
    end

    logic [31:0] mem [0:1023];
    always @(posedge hclk) begin
        if (o_we) mem[o_ma] <= o_wd;
        if (o_re) mem_rd <= mem[o_ma];
    end

    typedef struct {
        bit          is_wr;
        logic [9:0]  addr;
        logic [31:0] data;
    } sb_t;
    sb_t exp_q[$];

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic push(input bit is_wr, input logic [9:0] addr, input logic [31:0] data);
        sb_t e;
        e.is_wr = is_wr;
        e.addr  = addr;
        e.data  = data;
        exp_q.push_back(e);
    endtask

    task automatic mon();
        sb_t e;
        chk("we_re_exclusive", {31'd0, o_we & o_re}, 32'd0);
        if (o_we || o_re) begin
            chk("sb_nonempty", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("sb_kind_we", {31'd0, o_we}, {31'd0, e.is_wr});
                chk("sb_addr", {22'd0, o_ma}, {22'd0, e.addr});
                if (e.is_wr) chk("sb_wdata", o_wd, e.data);
            end
        end
    endtask

    task automatic cyc(input logic s, input logic [31:0] a, input logic [1:0] t,
                       input logic w, input logic [31:0] wd, input logic rdy);
        @(posedge hclk);
        #1;
        t_hsel = s; t_haddr = a; t_htrans = t; t_hwrite = w; t_hwdata = wd; t_hready = rdy;
        #1;
        mon();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rdy"},   {31'd0, o_rdy},  32'd1);
        chk({tag, "_resp"},  {31'd0, o_resp}, 32'd0);
        chk({tag, "_rdata"}, o_hrdata,        32'd0);
        chk({tag, "_we"},    {31'd0, o_we},   32'd0);
        chk({tag, "_re"},    {31'd0, o_re},   32'd0);
        chk({tag, "_maddr"}, {22'd0, o_ma},   32'd0);
        chk({tag, "_wd"},    o_wd,            32'd0);
    endtask

    initial begin
        sel = 0;
        hresetn = 1'b0;
        t_hsel = 1'b0; t_haddr = 32'd0; t_htrans = T_IDLE; t_hwrite = 1'b0;
        t_hwdata = 32'hFFFF_FFFF; t_hready = 1'b1;
        #2;
        chk_reset_outputs("reset");
        @(posedge hclk);
        #1 hresetn = 1'b1;

        // WAIT_C=0 write then pipelined read of 0x8
        push(1'b1, 10'd2, 32'hDEAD_BEEF);
        cyc(1, 32'h8, T_NONSEQ, 1, 32'd0, 1);
        chk("t1_aphase_rdy", {31'd0, o_rdy}, 32'd1);
        push(1'b0, 10'd2, 32'd0);
        cyc(1, 32'h8, T_NONSEQ, 0, 32'hDEAD_BEEF, 1);
        chk("t1_wr_we", {31'd0, o_we}, 32'd1);
        chk("t1_wr_rdy", {31'd0, o_rdy}, 32'd1);
        chk("t1_wr_resp", {31'd0, o_resp}, 32'd0);
        cyc(0, 32'd0, T_IDLE, 0, 32'd0, 1);
        chk("t1_rd_re", {31'd0, o_re}, 32'd1);
        chk("t1_rd_stall", {31'd0, o_rdy}, 32'd0);
        cyc(0, 32'd0, T_IDLE, 0, 32'd0, 1);
        chk("t1_rdata", o_hrdata, 32'hDEAD_BEEF);
        chk("t1_rd_rdy", {31'd0, o_rdy}, 32'd1);
        chk("t1_rd_resp", {31'd0, o_resp}, 32'd0);
        cyc(0, 32'd0, T_IDLE, 0, 32'd0, 1);
        chk("t1_rdata_idle", o_hrdata, 32'd0);
        chk("t1_drained", exp_q.size(), 32'd0);

        // preload word 4 for the wait-state reads
        push(1'b1, 10'd4, 32'hCAFE_F00D);
        cyc(1, 32'h10, T_NONSEQ, 1, 32'd0, 1);
        cyc(0, 32'd0, T_IDLE, 0, 32'hCAFE_F00D, 1);
        chk("pre_we", {31'd0, o_we}, 32'd1);

        // back-to-back NONSEQ writes
        push(1'b1, 10'd0, 32'h1111_1111);
        push(1'b1, 10'd1, 32'h2222_2222);
        push(1'b1, 10'd2, 32'h3333_3333);
        cyc(1, 32'h0, T_NONSEQ, 1, 32'd0, 1);
        chk("t4_rdy0", {31'd0, o_rdy}, 32'd1);
        cyc(1, 32'h4, T_NONSEQ, 1, 32'h1111_1111, 1);
        chk("t4_we1", {31'd0, o_we}, 32'd1);
        chk("t4_rdy1", {31'd0, o_rdy}, 32'd1);
        cyc(1, 32'h8, T_NONSEQ, 1, 32'h2222_2222, 1);
        chk("t4_we2", {31'd0, o_we}, 32'd1);
        chk("t4_rdy2", {31'd0, o_rdy}, 32'd1);
        cyc(0, 32'd0, T_IDLE, 0, 32'h3333_3333, 1);
        chk("t4_we3", {31'd0, o_we}, 32'd1);
        chk("t4_rdy3", {31'd0, o_rdy}, 32'd1);
        chk("t4_drained", exp_q.size(), 32'd0);

        // upper address bits are dropped: 0x1000_0008 aliases word 2
        push(1'b1, 10'd2, 32'h5A5A_5A5A);
        cyc(1, 32'h1000_0008, T_NONSEQ, 1, 32'd0, 1);
        cyc(0, 32'd0, T_IDLE, 0, 32'h5A5A_5A5A, 1);
        chk("wrap_we", {31'd0, o_we}, 32'd1);
        chk("wrap_resp", {31'd0, o_resp}, 32'd0);

        // misaligned write
        cyc(1, 32'h6, T_NONSEQ, 1, 32'd0, 1);
        cyc(0, 32'd0, T_IDLE, 0, 32'h1234_5678, 1);
        chk("t3_err1_resp", {31'd0, o_resp}, 32'd1);
        chk("t3_err1_rdy", {31'd0, o_rdy}, 32'd0);
        chk("t3_err1_we", {31'd0, o_we}, 32'd0);
        cyc(0, 32'd0, T_IDLE, 0, 32'd0, 1);
        chk("t3_err2_resp", {31'd0, o_resp}, 32'd1);
        chk("t3_err2_rdy", {31'd0, o_rdy}, 32'd1);
        chk("t3_err2_re", {31'd0, o_re}, 32'd0);
        cyc(0, 32'd0, T_IDLE, 0, 32'd0, 1);
        chk("t3_after_resp", {31'd0, o_resp}, 32'd0);

        // IDLE / BUSY / hready low are not accepted
        cyc(1, 32'h20, T_IDLE, 1, 32'd0, 1);
        chk("t5_idle_rdy", {31'd0, o_rdy}, 32'd1);
        cyc(1, 32'h20, T_BUSY, 1, 32'd0, 1);
        chk("t5_busy_rdy", {31'd0, o_rdy}, 32'd1);
        chk("t5_busy_we", {31'd0, o_we}, 32'd0);
        cyc(1, 32'h20, T_NONSEQ, 1, 32'd0, 0);
        chk("t5_nordy_we", {31'd0, o_we}, 32'd0);
        cyc(0, 32'd0, T_IDLE, 0, 32'd0, 1);
        chk("t5_after_we", {31'd0, o_we}, 32'd0);
        chk("t5_after_rdy", {31'd0, o_rdy}, 32'd1);
        chk("t5_after_resp", {31'd0, o_resp}, 32'd0);
        chk("t5_drained", exp_q.size(), 32'd0);

        // WAIT_C=3 read of 0x10
        sel = 3;
        push(1'b0, 10'd4, 32'd0);
        cyc(1, 32'h10, T_NONSEQ, 0, 32'd0, 1);
        chk("t2_aphase_rdy", {31'd0, o_rdy}, 32'd1);
        for (int i = 1; i <= 4; i++) begin
            cyc(0, 32'd0, T_IDLE, 0, 32'd0, 1);
            chk($sformatf("t2_stall%0d", i), {31'd0, o_rdy}, 32'd0);
            chk($sformatf("t2_re%0d", i), {31'd0, o_re}, {31'd0, i == 4});
        end
        cyc(0, 32'd0, T_IDLE, 0, 32'd0, 1);
        chk("t2_rdata", o_hrdata, 32'hCAFE_F00D);
        chk("t2_rdy", {31'd0, o_rdy}, 32'd1);
        chk("t2_drained", exp_q.size(), 32'd0);

        // WAIT_C=2 read aborted by reset in WAIT, then a clean read
        sel = 2;
        push(1'b0, 10'd4, 32'd0);
        cyc(1, 32'h10, T_NONSEQ, 0, 32'd0, 1);
        cyc(0, 32'd0, T_IDLE, 0, 32'd0, 1);
        chk("t6_wait_rdy", {31'd0, o_rdy}, 32'd0);
        #1 hresetn = 1'b0;
        #1;
        exp_q.delete();
        chk_reset_outputs("t6_abort");
        for (int i = 0; i < 3; i++) begin
            cyc(0, 32'd0, T_IDLE, 0, 32'd0, 1);
            chk($sformatf("t6_held_re%0d", i), {31'd0, o_re}, 32'd0);
        end
        @(negedge hclk);
        hresetn = 1'b1;
        push(1'b0, 10'd4, 32'd0);
        cyc(1, 32'h10, T_NONSEQ, 0, 32'd0, 1);
        for (int i = 1; i <= 3; i++) begin
            cyc(0, 32'd0, T_IDLE, 0, 32'd0, 1);
            chk($sformatf("t6_stall%0d", i), {31'd0, o_rdy}, 32'd0);
            chk($sformatf("t6_re%0d", i), {31'd0, o_re}, {31'd0, i == 3});
        end
        cyc(0, 32'd0, T_IDLE, 0, 32'd0, 1);
        chk("t6_rdata", o_hrdata, 32'hCAFE_F00D);
        chk("t6_rdy", {31'd0, o_rdy}, 32'd1);
        chk("t6_drained", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
